// File: rtl/pi_integrator.sv
// pi_integrator: saturating power-of-two-gain integrator with anti-windup; `INTEGRATOR_LEAK_EN adds a leak term
module pi_integrator #(
  parameter int E_W        = 8,
  parameter int ACC_W      = 16,
  parameter int OUT_W      = 8,
  parameter int SHIFT_W    = 4,
  parameter int LEAK_SHIFT = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      e_valid,
  input  logic signed [E_W-1:0]     e,
  input  logic        [SHIFT_W-1:0] k_shift,
  input  logic                      hold,
  input  logic                      clr,
  output logic signed [OUT_W-1:0]   i_contrib,
  output logic                      i_valid,
  output logic                      sat_flag
);
  localparam logic signed [ACC_W-1:0] A_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] A_MIN = ~A_MAX;
  localparam logic signed [ACC_W-1:0] O_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] O_MIN = ~O_MAX;
  if (ACC_W < E_W + 1 || OUT_W > ACC_W || OUT_W < 2 || LEAK_SHIFT < 1 || LEAK_SHIFT >= ACC_W) begin : g_bad_params
    $error("pi_integrator: illegal parameter combination");
  end
  logic signed [ACC_W-1:0]   acc, acc_nx, scaled, scaled_c;
  logic        [SHIFT_W-1:0] k_q;
  logic                      pend, block;
  logic signed [E_W-1:0]     e_eff;
  logic signed [ACC_W:0]     sum;
  logic        [31:0]        sh;
  // same-sign (or any nonzero on a zero accumulator) samples would push further into saturation
  assign block = hold && e != '0 && (acc == '0 || e[E_W-1] == acc[ACC_W-1]);
  assign e_eff = block ? '0 : e;
`ifdef INTEGRATOR_LEAK_EN
  logic signed [ACC_W-1:0] leak;
  assign leak = acc >>> LEAK_SHIFT;
  assign sum  = {acc[ACC_W-1], acc} + {{(ACC_W+1-E_W){e_eff[E_W-1]}}, e_eff} - {leak[ACC_W-1], leak};
`else
  assign sum  = {acc[ACC_W-1], acc} + {{(ACC_W+1-E_W){e_eff[E_W-1]}}, e_eff};
`endif
  assign acc_nx   = (sum[ACC_W] != sum[ACC_W-1]) ? (sum[ACC_W] ? A_MIN : A_MAX) : sum[ACC_W-1:0];
  assign sh       = (32'(k_q) > 32'(ACC_W-1)) ? 32'(ACC_W-1) : 32'(k_q);
  assign scaled   = acc >>> sh;
  assign scaled_c = (scaled > O_MAX) ? O_MAX : (scaled < O_MIN) ? O_MIN : scaled;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      k_q       <= '0;
      pend      <= 1'b0;
      i_contrib <= '0;
      i_valid   <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (!ena) begin
      i_valid <= 1'b0;
    end else if (clr) begin
      acc       <= '0;
      pend      <= 1'b0;
      i_contrib <= '0;
      i_valid   <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      i_valid <= pend;
      pend    <= e_valid;
      if (pend) i_contrib <= scaled_c[OUT_W-1:0];
      if (e_valid) begin
        acc      <= acc_nx;
        k_q      <= k_shift;
        sat_flag <= acc_nx == A_MAX || acc_nx == A_MIN;
      end
    end
  end
endmodule

// File: doc/pi_integrator.md
# pi_integrator

Parametrised signed integrator for the PID datapath: accumulates the error sample, scales by a power-of-two integral gain (arithmetic right shift) and delivers a saturated integral contribution to the control summer. It supersedes the fixed-width integrator with the following additions:

- configurable widths
- sample-valid handshake
- accumulator saturation
- conditional-integration anti-windup
- synchronous clear
- optional leak

## Interface
- `E_W`, 8, error sample width (signed two's complement)
- `ACC_W`, 16, accumulator width (signed); must be ≥ `E_W` + 1
- `OUT_W`, 8, output contribution width (signed); must be ≤ `ACC_W`
- `SHIFT_W`, 4, width of gain shift code
- `LEAK_SHIFT`, 6, leak divisor exponent (used only with `INTEGRATOR_LEAK_EN`)

- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `ena`  in  1  global enable; low freezes all state and forces `i_valid` low
- `e_valid`  in  1  qualifies `e` and `k_shift` for one cycle
- `e`  in  `E_W`  signed error sample
- `k_shift`  in  `SHIFT_W`  integral gain as right-shift amount: gain = 2^-`k_shift`
- `hold`  in  1  anti-windup request from downstream output saturation
- `clr`  in  1  synchronous accumulator clear
- `i_contrib`  out  `OUT_W`  signed integral contribution
- `i_valid`  out  1  one-cycle pulse, `i_contrib` updated
- `sat_flag`  out  1  accumulator sits at either saturation limit

## Operation
- **Stage 1 (accumulate)** runs on `ena && e_valid && !clr`.
  - `sum = acc + sext(e)`, computed at `ACC_W`+1 bits.
  - `sum` is clamped to [−2^(`ACC_W`−1), 2^(`ACC_W`−1)−1] and written to `acc`.
  - `k_shift` is captured into `k_q` in the same cycle.
- **Anti-windup:** with `hold`=1, a sample with `e` ≠ 0 and sign(`e`) = sign(`acc`) is not integrated; `acc` is unchanged. An opposite-sign sample is integrated normally. For `acc` = 0, any nonzero `e` is blocked. A blocked sample still produces an `i_valid` pulse.
- **Stage 2 (scale)** runs the cycle after an accepted sample.
  - `scaled = acc >>> min(k_q, ACC_W−1)`: arithmetic shift, rounding toward −∞.
  - `scaled` is clamped to the `OUT_W` signed range, registered to `i_contrib`, and `i_valid` pulses.
- `sat_flag` is registered: 1 when `acc` equals either limit after the stage-1 update.
- **`clr` (with `ena`)** has priority over `e_valid`. It does the following next cycle:
  - `acc` = 0 and `i_contrib` = 0
  - `sat_flag` = 0
  - `i_valid` = 0
  - discards any pending stage-2 update
  - drops a same-cycle sample
- **`ena`=0:** `acc`, `k_q` and `i_contrib` hold. A stage-2 update in flight is deferred until `ena` returns. `e_valid`, `clr` and `hold` are ignored while `ena`=0.
- `k_shift` changes between samples have no effect until the next accepted sample.

## Timing
- Reset (`rst_n`=0 at a rising edge) sets:
  - `acc`=0, `k_q`=0
  - `i_contrib`=0, `i_valid`=0, `sat_flag`=0
  - pipeline empty
- Reset mid-operation discards the in-flight update.
- **Latency:** `e_valid` at edge N updates `acc` at N and `sat_flag` at N. `i_contrib`/`i_valid` update at edge N+1, i.e. visible 2 cycles after the sample is presented.
- **Throughput:** one sample per cycle; back-to-back `e_valid` yields back-to-back `i_valid`.
- No backpressure; the consumer must accept every `i_valid` pulse.

## Configuration
- **`INTEGRATOR_LEAK_EN` defined:** accepted samples compute `sum = acc + sext(e) − (acc >>> LEAK_SHIFT)` before clamping. `acc` decays toward 0 under zero error. The leak term is also applied to blocked `hold` samples, with `e` treated as 0.
- **Not defined:** pure integration; `LEAK_SHIFT` is unused and no leak logic is synthesised.

## Test plan
All scenarios use default parameters and run without the macro unless stated.
- **Reset:** hold `rst_n`=0 for 5 cycles after driving nonzero inputs -> `i_contrib`=0, `i_valid`=0, `sat_flag`=0. Release; `e`=1, `k_shift`=0, three back-to-back samples -> `i_contrib` 1, 2, 3 with `i_valid` high on three consecutive cycles, first 2 cycles after the first sample.
- **Gain shift:** `acc`=3, `e`=2, `k_shift`=1 -> `i_contrib`=2. Then `e`=−8, `k_shift`=1 (`acc`=−3) -> `i_contrib`=−2 (floor rounding). With `k_shift`=15 and `acc`=−3 -> −1.
- **Saturation:** `e`=127 for 260 samples -> `acc`=32767, `sat_flag`=1, `i_contrib`=127 (`k_shift`=0) and 127 (`k_shift`=8). Then `e`=−128 once -> `sat_flag`=0.
- **Anti-windup:** `acc`=100, `hold`=1, `e`=+5 -> `acc` stays 100 and `i_valid` still pulses. Then `e`=−5 -> `acc`=95, `i_contrib`=95.
- **Clear/enable:** `clr` and `e_valid` (`e`=7) in the same cycle -> `acc`=0, no `i_valid`. A sample with `ena` dropped the next cycle -> `i_contrib` holds, updates one cycle after `ena` returns.
- **Leak (with `INTEGRATOR_LEAK_EN`):** `acc`=640, `e`=0 sample -> `acc`=630.
